// File: rtl/modulation_segment_scheduler_pkg.sv
`timescale 1ns/1ps
// Shared widths, transition-mode codes and FSM state type for the modulation segment scheduler.
// GPIO transition mode is accepted only when MOD_TRANSITION_GPIO_EN is defined.
package mod_sched_pkg;

    localparam int IDX_W = 15;
    localparam int REP_W = 16;

    localparam logic [7:0] TRANS_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANS_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANS_GPIO      = 8'h02;
    localparam logic [7:0] TRANS_IMMEDIATE = 8'hFF;

    localparam logic [REP_W-1:0] REP_INFINITE = '1;

`ifdef MOD_TRANSITION_GPIO_EN
    localparam bit GPIO_EN = 1'b1;
`else
    localparam bit GPIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        WAIT    = 2'd1,
        STOPPED = 2'd2
    } schedState_e;

    // Unknown mode codes make an UPDATE a no-op.
    function automatic logic modeValid(input logic [7:0] mode);
        return (mode == TRANS_SYNC_IDX) || (mode == TRANS_SYS_TIME) ||
               (mode == TRANS_IMMEDIATE) || (GPIO_EN && (mode == TRANS_GPIO));
    endfunction

endpackage

// File: rtl/modulation_segment_scheduler_if.sv
`timescale 1ns/1ps
// Configuration-side bus of the scheduler: swap requests in, segment/index/status out.
interface modulation_segment_scheduler_if;
    import mod_sched_pkg::*;

    logic             update;
    logic             reqSegment;
    logic [REP_W-1:0] reqRep;
    logic [7:0]       transitionMode;
    logic [63:0]      transitionValue;

    logic             segment;
    logic [IDX_W-1:0] idx;
    logic             stop;
    logic             busy;

    modport master (
        output update, reqSegment, reqRep, transitionMode, transitionValue,
        input  segment, idx, stop, busy
    );

    modport slave (
        input  update, reqSegment, reqRep, transitionMode, transitionValue,
        output segment, idx, stop, busy
    );

endinterface

// File: rtl/modulation_segment_scheduler_wrap_detect.sv
`timescale 1ns/1ps
// Remembers last cycle's timer index and flags a wrap when the index moves backwards.
module mod_wrap_detect
    import mod_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    output logic             wrap_o
);

    logic [IDX_W-1:0] prevIdx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevIdx_q <= '0;
        end else begin
            prevIdx_q <= idx_i;
        end
    end

    assign wrap_o = prevIdx_q > idx_i;

endmodule

// File: rtl/modulation_segment_scheduler.sv
`timescale 1ns/1ps
// Chooses which modulation segment feeds the sampler, times requested swaps and stops finite plays.
// Optional GPIO-triggered swaps are built when MOD_TRANSITION_GPIO_EN is defined.
module modulation_segment_scheduler
    import mod_sched_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    modulation_segment_scheduler_if.slave bus,
    input  logic [63:0]                   sys_time_i,
    input  logic [IDX_W-1:0]              cycle_0_i,
    input  logic [IDX_W-1:0]              cycle_1_i,
    input  logic [IDX_W-1:0]              idx_0_i,
    input  logic [IDX_W-1:0]              idx_1_i,
    input  logic [3:0]                    gpio_i
);

    schedState_e      state_q;
    logic             segment_q;
    logic             stop_q;
    logic             busy_q;
    logic [IDX_W-1:0] idx_q;
    logic [REP_W-1:0] repActive_q;
    logic [REP_W-1:0] playCnt_q;

    logic             pendSegment_q;
    logic [REP_W-1:0] pendRep_q;
    logic [7:0]       pendMode_q;
    logic [63:0]      pendValue_q;

    logic             wrap0;
    logic             wrap1;
    logic             gpioRise;
    logic             swapNow;
    logic             activeWrap;
    logic             requestValid;
    logic [IDX_W-1:0] activeIdx;
    logic [IDX_W-1:0] activeCycle;
    logic [IDX_W-1:0] pendIdx;

    mod_wrap_detect wrapDetect0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .idx_i  (idx_0_i),
        .wrap_o (wrap0)
    );

    mod_wrap_detect wrapDetect1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .idx_i  (idx_1_i),
        .wrap_o (wrap1)
    );

    assign activeWrap   = segment_q ? wrap1 : wrap0;
    assign activeIdx    = segment_q ? idx_1_i : idx_0_i;
    assign activeCycle  = segment_q ? cycle_1_i : cycle_0_i;
    assign pendIdx      = pendSegment_q ? idx_1_i : idx_0_i;
    assign requestValid = bus.update && modeValid(bus.transitionMode);

`ifdef MOD_TRANSITION_GPIO_EN
    logic [3:0] gpioMeta_q;
    logic [3:0] gpioSync_q;
    logic [3:0] gpioPrev_q;

    // Two-flop synchroniser followed by an edge-detect stage on the selected pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpioMeta_q <= '0;
            gpioSync_q <= '0;
            gpioPrev_q <= '0;
        end else begin
            gpioMeta_q <= gpio_i;
            gpioSync_q <= gpioMeta_q;
            gpioPrev_q <= gpioSync_q;
        end
    end

    assign gpioRise = gpioSync_q[pendValue_q[1:0]] & ~gpioPrev_q[pendValue_q[1:0]];
`else
    logic unusedGpio;
    assign unusedGpio = ^gpio_i;
    assign gpioRise   = 1'b0;
`endif

    always_comb begin
        swapNow = 1'b0;
        case (pendMode_q)
            TRANS_SYNC_IDX:  swapNow = pendSegment_q ? wrap1 : wrap0;
            TRANS_SYS_TIME:  swapNow = sys_time_i >= pendValue_q;
            TRANS_GPIO:      swapNow = gpioRise;
            TRANS_IMMEDIATE: swapNow = 1'b1;
            default:         swapNow = 1'b0;
        endcase
    end

    // A new request is applied after the state update so it wins when it coincides with a swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLAY;
            segment_q     <= 1'b0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            idx_q         <= '0;
            repActive_q   <= REP_INFINITE;
            playCnt_q     <= '0;
            pendSegment_q <= 1'b0;
            pendRep_q     <= REP_INFINITE;
            pendMode_q    <= TRANS_SYNC_IDX;
            pendValue_q   <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (swapNow) begin
                        state_q     <= PLAY;
                        segment_q   <= pendSegment_q;
                        repActive_q <= pendRep_q;
                        playCnt_q   <= '0;
                        stop_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        idx_q       <= pendIdx;
                    end else begin
                        idx_q <= stop_q ? activeCycle : activeIdx;
                    end
                end
                PLAY: begin
                    if (activeWrap && (repActive_q != REP_INFINITE) && (playCnt_q == repActive_q)) begin
                        state_q <= STOPPED;
                        stop_q  <= 1'b1;
                        idx_q   <= activeCycle;
                    end else begin
                        if (activeWrap) begin
                            playCnt_q <= playCnt_q + REP_W'(1);
                        end
                        idx_q <= activeIdx;
                    end
                end
                STOPPED: begin
                    idx_q <= activeCycle;
                end
                default: begin
                    state_q <= PLAY;
                end
            endcase

            if (requestValid) begin
                pendSegment_q <= bus.reqSegment;
                pendRep_q     <= bus.reqRep;
                pendMode_q    <= bus.transitionMode;
                pendValue_q   <= bus.transitionValue;
                state_q       <= WAIT;
                busy_q        <= 1'b1;
            end
        end
    end

    assign bus.segment = segment_q;
    assign bus.idx     = idx_q;
    assign bus.stop    = stop_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_modulation_segment_scheduler.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for modulation_segment_scheduler; a behavioural model predicts
// every cycle's outputs and a separate monitor compares them against the DUT.
module tb_modulation_segment_scheduler;
    import mod_sched_pkg::*;

    typedef struct {
        logic             segment;
        logic [IDX_W-1:0] idx;
        logic             stop;
        logic             busy;
    } expect_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0]      sysTime;
    logic [IDX_W-1:0] cycle0, cycle1, idx0, idx1;
    logic [3:0]       gpio;

    logic [63:0]      sysTimeNext;
    logic [IDX_W-1:0] cycle0Next, cycle1Next;
    logic [3:0]       gpioNext;
    bit               stallEnable;

    modulation_segment_scheduler_if bus();

    modulation_segment_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sys_time_i (sysTime),
        .cycle_0_i  (cycle0),
        .cycle_1_i  (cycle1),
        .idx_0_i    (idx0),
        .idx_1_i    (idx1),
        .gpio_i     (gpio)
    );

    always #5 clk = ~clk;

    expect_t expQ[$];
    int      testsRun = 0;
    int      testsFailed = 0;

    // Reference model: active segment, stop flag, pending request and plays started since the last swap.
    bit               mSeg, mStop, mWaiting;
    logic [REP_W-1:0] mRep;
    int               mPlays;
    bit               pSeg;
    logic [REP_W-1:0] pRep;
    logic [7:0]       pMode;
    logic [63:0]      pValue;
    int               prevIdx0, prevIdx1;
`ifdef MOD_TRANSITION_GPIO_EN
    logic [3:0]       gHist [1:3];
`endif

    function automatic bit isValidMode(input logic [7:0] mode);
`ifdef MOD_TRANSITION_GPIO_EN
        return mode == 8'h00 || mode == 8'h01 || mode == 8'hFF || mode == 8'h02;
`else
        return mode == 8'h00 || mode == 8'h01 || mode == 8'hFF;
`endif
    endfunction

    task automatic modelReset();
        mSeg = 1'b0; mStop = 1'b0; mWaiting = 1'b0; mRep = '1; mPlays = 1;
        pSeg = 1'b0; pRep = '1; pMode = 8'h00; pValue = '0;
        prevIdx0 = 0; prevIdx1 = 0;
`ifdef MOD_TRANSITION_GPIO_EN
        for (int k = 1; k <= 3; k++) gHist[k] = '0;
`endif
    endtask

    // Drives one cycle of inputs at the falling edge and queues the outputs expected after the next rising edge.
    task automatic applyStimulus(input bit doReset, input bit upd, input bit seg,
                                 input logic [REP_W-1:0] rep, input logic [7:0] mode,
                                 input logic [63:0] value);
        bit      wrap0, wrap1, activeWrap, swap, gpioEdge;
        expect_t e;
        @(negedge clk);
        sysTime     = sysTimeNext;
        sysTimeNext = sysTimeNext + 64'd1;
        cycle0      = cycle0Next;
        cycle1      = cycle1Next;
        gpio        = gpioNext;
        if (!stallEnable || $urandom_range(0, 3) != 0) begin
            idx0 = (idx0 >= cycle0) ? '0 : idx0 + 1'b1;
            idx1 = (idx1 >= cycle1) ? '0 : idx1 + 1'b1;
        end
        rst_n               = !doReset;
        bus.update          = upd;
        bus.reqSegment      = seg;
        bus.reqRep          = rep;
        bus.transitionMode  = mode;
        bus.transitionValue = value;

        if (doReset) begin
            modelReset();
            e = '{segment: 1'b0, idx: '0, stop: 1'b0, busy: 1'b0};
        end else begin
            wrap0    = int'(idx0) < prevIdx0;
            wrap1    = int'(idx1) < prevIdx1;
            gpioEdge = 1'b0;
`ifdef MOD_TRANSITION_GPIO_EN
            gpioEdge = (pMode == 8'h02) && gHist[2][pValue[1:0]] && !gHist[3][pValue[1:0]];
`endif
            swap = mWaiting && ((pMode == 8'hFF) ||
                                (pMode == 8'h01 && sysTime >= pValue) ||
                                (pMode == 8'h00 && (pSeg ? wrap1 : wrap0)) ||
                                gpioEdge);
            activeWrap = mSeg ? wrap1 : wrap0;
            if (swap) begin
                mSeg = pSeg; mRep = pRep; mPlays = 1; mStop = 1'b0; mWaiting = 1'b0;
            end else if (!mWaiting && !mStop && activeWrap) begin
                mPlays++;
                if (mRep != '1 && mPlays == int'(mRep) + 2) mStop = 1'b1;
            end
            if (upd && isValidMode(mode)) begin
                pSeg = seg; pRep = rep; pMode = mode; pValue = value; mWaiting = 1'b1;
            end
            prevIdx0 = int'(idx0);
            prevIdx1 = int'(idx1);
`ifdef MOD_TRANSITION_GPIO_EN
            gHist[3] = gHist[2];
            gHist[2] = gHist[1];
            gHist[1] = gpio;
`endif
            e.segment = mSeg;
            e.stop    = mStop;
            e.busy    = mWaiting;
            e.idx     = mStop ? (mSeg ? cycle1 : cycle0) : (mSeg ? idx1 : idx0);
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '1, 8'h00, 64'd0);
    endtask

    task automatic request(input bit seg, input logic [REP_W-1:0] rep,
                           input logic [7:0] mode, input logic [63:0] value);
        applyStimulus(1'b0, 1'b1, seg, rep, mode, value);
    endtask

    task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareField("segment", 32'(bus.segment), 32'(e.segment));
        compareField("idx",     32'(bus.idx),     32'(e.idx));
        compareField("stop",    32'(bus.stop),    32'(e.stop));
        compareField("busy",    32'(bus.busy),    32'(e.busy));
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [7:0]       mode;
        logic [REP_W-1:0] rep;

        sysTime = '0; sysTimeNext = '0;
        cycle0 = IDX_W'(9); cycle1 = IDX_W'(4); cycle0Next = IDX_W'(9); cycle1Next = IDX_W'(4);
        idx0 = '0; idx1 = '0; gpio = '0; gpioNext = '0; stallEnable = 1'b0;
        bus.update = 1'b0; bus.reqSegment = 1'b0; bus.reqRep = '1;
        bus.transitionMode = 8'h00; bus.transitionValue = '0;
        modelReset();

        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, '1, 8'h00, 64'd0);
        idle(12);

        request(1'b1, '1, 8'h00, 64'd0);
        idle(15);

        sysTimeNext = 64'd900;
        request(1'b0, '1, 8'h01, 64'd1000);
        idle(105);
        request(1'b1, '1, 8'h01, 64'd500);
        idle(3);

        cycle0Next = IDX_W'(3);
        request(1'b0, REP_W'(2), 8'hFF, 64'd0);
        idle(20);
        request(1'b0, '1, 8'hFF, 64'd0);
        idle(6);

        request(1'b1, '1, 8'h55, 64'd0);
        idle(3);
        request(1'b0, '1, 8'h01, sysTimeNext + 64'd1000);
        idle(2);
        request(1'b1, '1, 8'hFF, 64'd0);
        idle(3);

        request(1'b0, '1, 8'hFF, 64'd0);
        request(1'b1, '1, 8'hFF, 64'd0);
        idle(3);

        request(1'b0, '1, 8'h02, 64'd1);
        idle(3);
        gpioNext = 4'b0010;
        idle(6);
        gpioNext = 4'b0000;
        idle(3);

        request(1'b1, '1, 8'h01, sysTimeNext + 64'd500);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, '1, 8'h00, 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, '1, 8'h00, 64'd0);
        idle(5);
        request(1'b0, REP_W'(0), 8'hFF, 64'd0);
        idle(15);
        applyStimulus(1'b1, 1'b0, 1'b0, '1, 8'h00, 64'd0);
        idle(3);

        stallEnable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) begin
                cycle0Next = IDX_W'($urandom_range(1, 7));
                cycle1Next = IDX_W'($urandom_range(1, 7));
            end
            if ($urandom_range(0, 5) == 0) gpioNext = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                applyStimulus(1'b1, 1'b0, 1'b0, '1, 8'h00, 64'd0);
            end else if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0:       mode = 8'h00;
                    1:       mode = 8'h01;
                    2:       mode = 8'hFF;
                    3:       mode = 8'h55;
                    default: mode = 8'h02;
                endcase
                rep = ($urandom_range(0, 2) == 0) ? '1 : REP_W'($urandom_range(0, 3));
                request(1'($urandom_range(0, 1)), rep, mode,
                        sysTimeNext - 64'd10 + 64'($urandom_range(0, 50)));
            end else begin
                idle(1);
            end
        end

        @(posedge clk);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d queued entries, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
